grouped_ec_mac_array: RTL and testbench
=======================================

// Module: grouped_ec_mac_array
// PURPOSE
//  Parametrised successor of the fixed 4-MAC error-compensation group: a chain of GROUP_SIZE
//  signed MAC stages with a valid handshake and a runtime compensation enable.
//  A stage flagged with a timing error withholds its product, and the next stage adds it.
//  Error product/flag chain in from the upstream group and out to the downstream group.
//  Keeps a saturating count of flagged errors.
//  Sits in one column of the low-voltage DNN systolic array, between neighbouring groups.
// PARAMETERS
//  GROUP_SIZE  4   number of MAC stages in the group (>=2)
//  DATA_W      8   weight/activation width, signed
//  ACC_W       24  partial-sum width (>= 2*DATA_W+clog2(GROUP_SIZE+1))
//  CNT_W       16  error-counter width
// PORTS
//  clk          in   1                 single clock, rising edge
//  rst_n        in   1                 asynchronous active-low reset
//  in_valid     in   1                 token accepted this cycle
//  weight_i     in   GROUP_SIZE*DATA_W stage k weight = bits [k*DATA_W +: DATA_W]
//  act_i        in   GROUP_SIZE*DATA_W stage k activation, same packing
//  err_flag_i   in   GROUP_SIZE        per-stage timing-error flag from the stage sensors
//  psum_i       in   ACC_W             partial sum from the upstream group
//  err_prod_i   in   2*DATA_W          withheld product from the upstream group
//  err_i        in   1                 err_prod_i is pending
//  comp_en      in   1                 1: compensate; 0: ignore err_flag_i/err_i
//  clr_cnt      in   1                 synchronous clear of err_cnt_o
//  act_o        out  GROUP_SIZE*DATA_W activations forwarded to the neighbour group
//  out_valid    out  1                 psum_o/err_prod_o/err_o valid
//  psum_o       out  ACC_W             partial sum to the downstream group
//  err_prod_o   out  2*DATA_W          product withheld by the last stage
//  err_o        out  1                 err_prod_o is pending
//  err_cnt_o    out  CNT_W             count of accepted stage errors, saturating
// BEHAVIOUR
//  - Reset: every register and output is 0, including out_valid, err_o and err_cnt_o.
//    rst_n asserted mid-operation flushes all in-flight tokens; they are lost.
//  - Accept: on in_valid, capture all operands and flags. Stage k uses them k cycles later
//    via the internal skew registers.
//  - Latency: out_valid is asserted exactly GROUP_SIZE cycles after in_valid.
//    Throughput is 1 token/cycle. Bubbles propagate with valid=0.
//    Idle stages hold their data registers.
//  - act_o: act_i registered once on in_valid (1-cycle forward); held when in_valid=0.
//  - Stage k: prod_k = $signed(w_k)*$signed(a_k), 2*DATA_W wide. It is sign-extended
//    before it is added. Pending input (p,e): stage 0 takes (err_prod_i,err_i); stage k
//    takes the pending output of stage k-1.
//      comp_en=0 or (e=0,f=0): sum += prod_k (plus p if e); pending out = 0
//      f=1, e=0: sum unchanged; pending out = (prod_k, 1)
//      f=0, e=1: sum += prod_k + p; pending out = 0
//      f=1, e=1: sum += p; pending out = (prod_k, 1)
//  - comp_en=0 also ignores err_i: err_prod_i is not added and err_o is 0. Errors are not counted.
//  - The last stage's pending output drives err_prod_o/err_o. err_prod_o is 0 whenever err_o=0.
//  - Arithmetic is two's complement, modulo 2^ACC_W. Overflow wraps; no flag.
//  - err_cnt_o adds popcount(err_flag_i) per accepted token when comp_en=1. It saturates at
//    2^CNT_W-1. If clr_cnt and an increment happen in the same cycle, the clear wins.
//  - comp_en is sampled with the token at accept. Toggling it mid-flight affects only later tokens.
// STRUCTURE
//  - Shared package ec_mac_pkg: default widths, a packed stage-token typedef
//    {valid, psum, err_prod, err} and the signed sign-extend/product helper functions.
//  - One sub-module, ec_mac_stage: one register stage implementing the table above.
//    It is instantiated GROUP_SIZE times by a generate loop.
//  - The top level holds the skew registers, the act_o register and the error counter.
// TESTING
//  1. Reset: rst_n=0 with random inputs -> all outputs 0. Release rst_n -> out_valid stays 0
//     until the first token is accepted.
//  2. No errors: w=a=all 3, psum_i=10 -> psum_o=46 after 4 cycles, err_o=0, err_cnt_o=0.
//  3. Stage 1 error: w=a={2,3,4,5}, f=4'b0010 -> psum_o=54 (all products), err_o=0,
//     err_cnt_o=1.
//  4. Last-stage error: w=a={2,3,4,5}, f=4'b1000 -> psum_o=29, err_o=1, err_prod_o=25.
//     Upstream pending: err_i=1, err_prod_i=-7, f=0 -> psum_o = psum_i+54-7.
//  5. comp_en=0 with f=4'b1111, err_i=1 -> err_prod_i ignored, full sum returned, err_o=0,
//     counter unchanged.
//  6. Back-to-back tokens with a bubble, then rst_n pulsed mid-flight ->
//     outputs in order with correct gaps; flushed tokens never appear.
//     Also: counter saturation at CNT_W=2, and clr_cnt winning over a simultaneous increment.

Source files
------------

// File: rtl/ec_mac_pkg.sv
// ec_mac_pkg: shared default widths, stage token type and signed arithmetic helpers
package ec_mac_pkg;
    localparam int GROUP_SIZE_D = 4;
    localparam int DATA_W_D     = 8;
    localparam int ACC_W_D      = 24;
    localparam int CNT_W_D      = 16;
    localparam int MUL_W        = 64;
    typedef struct packed {
        logic                  valid;
        logic [ACC_W_D-1:0]    psum;
        logic [2*DATA_W_D-1:0] err_prod;
        logic                  err;
    } stage_tok_t;
    function automatic logic signed [MUL_W-1:0] mul_s(input logic signed [MUL_W-1:0] a,
                                                      input logic signed [MUL_W-1:0] b);
        return a * b;
    endfunction
    function automatic logic signed [MUL_W-1:0] sext(input logic signed [MUL_W-1:0] x);
        return x;
    endfunction
endpackage

// File: rtl/ec_mac_stage.sv
// ec_mac_stage: one signed MAC register stage that can withhold its product for the next stage
module ec_mac_stage
    import ec_mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int ACC_W  = ACC_W_D
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic                comp_en,
    input  logic [DATA_W-1:0]   weight,
    input  logic [DATA_W-1:0]   act,
    input  logic                err_flag,
    input  logic [ACC_W-1:0]    psum_i,
    input  logic [2*DATA_W-1:0] err_prod_i,
    input  logic                err_i,
    output logic                valid_o,
    output logic [ACC_W-1:0]    psum_o,
    output logic [2*DATA_W-1:0] err_prod_o,
    output logic                err_o
);
    localparam int PW = 2*DATA_W;
    logic [PW-1:0]    prod;
    logic             hold;
    logic             take;
    logic [ACC_W-1:0] psum_nxt;
    always_comb begin
        prod     = PW'(mul_s(sext(MUL_W'($signed(weight))), sext(MUL_W'($signed(act)))));
        hold     = comp_en & err_flag;
        take     = comp_en & err_i;
        psum_nxt = psum_i + (hold ? '0 : ACC_W'($signed(prod)))
                          + (take ? ACC_W'($signed(err_prod_i)) : '0);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid_o    <= 1'b0;
            psum_o     <= '0;
            err_prod_o <= '0;
            err_o      <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                psum_o     <= psum_nxt;
                err_prod_o <= hold ? prod : '0;
                err_o      <= hold;
            end
        end
endmodule

// File: rtl/grouped_ec_mac_array.sv
// grouped_ec_mac_array: chain of error-compensating MAC stages with operand skew and error counter
module grouped_ec_mac_array
    import ec_mac_pkg::*;
#(
    parameter int GROUP_SIZE = GROUP_SIZE_D,
    parameter int DATA_W     = DATA_W_D,
    parameter int ACC_W      = ACC_W_D,
    parameter int CNT_W      = CNT_W_D
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [GROUP_SIZE*DATA_W-1:0] weight_i,
    input  logic [GROUP_SIZE*DATA_W-1:0] act_i,
    input  logic [GROUP_SIZE-1:0]        err_flag_i,
    input  logic [ACC_W-1:0]             psum_i,
    input  logic [2*DATA_W-1:0]          err_prod_i,
    input  logic                         err_i,
    input  logic                         comp_en,
    input  logic                         clr_cnt,
    output logic [GROUP_SIZE*DATA_W-1:0] act_o,
    output logic                         out_valid,
    output logic [ACC_W-1:0]             psum_o,
    output logic [2*DATA_W-1:0]          err_prod_o,
    output logic                         err_o,
    output logic [CNT_W-1:0]             err_cnt_o
);
    localparam int LW  = 2*DATA_W+2;
    localparam int PCW = $clog2(GROUP_SIZE+1);
    localparam int SW  = CNT_W+PCW;
    logic                               head_valid;
    logic                               head_err;
    logic [ACC_W-1:0]                   head_psum;
    logic [2*DATA_W-1:0]                head_err_prod;
    logic [GROUP_SIZE:0]                v;
    logic [GROUP_SIZE:0]                e;
    logic [GROUP_SIZE:0][ACC_W-1:0]     ps;
    logic [GROUP_SIZE:0][2*DATA_W-1:0]  ep;
    logic [PCW-1:0]                     pop;
    logic [SW-1:0]                      cnt_sum;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            head_valid    <= 1'b0;
            head_psum     <= '0;
            head_err_prod <= '0;
            head_err      <= 1'b0;
        end else begin
            head_valid <= in_valid;
            if (in_valid) begin
                head_psum     <= psum_i;
                head_err_prod <= err_prod_i;
                head_err      <= err_i;
            end
        end
    assign v[0]  = head_valid;
    assign ps[0] = head_psum;
    assign ep[0] = head_err_prod;
    assign e[0]  = head_err;
    // lane k = {weight, act, flag, comp_en}; lane[0] is the accept register, lane[k] feeds stage k
    for (genvar k = 0; k < GROUP_SIZE; k++) begin : g_stage
        logic [LW-1:0] lane [0:k];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                for (int j = 0; j <= k; j++) lane[j] <= '0;
            end else begin
                if (in_valid)
                    lane[0] <= {weight_i[k*DATA_W +: DATA_W], act_i[k*DATA_W +: DATA_W],
                                err_flag_i[k], comp_en};
                for (int j = 1; j <= k; j++) lane[j] <= lane[j-1];
            end
        assign act_o[k*DATA_W +: DATA_W] = lane[0][2 +: DATA_W];
        ec_mac_stage #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .valid_i    (v[k]),
            .comp_en    (lane[k][0]),
            .weight     (lane[k][DATA_W+2 +: DATA_W]),
            .act        (lane[k][2 +: DATA_W]),
            .err_flag   (lane[k][1]),
            .psum_i     (ps[k]),
            .err_prod_i (ep[k]),
            .err_i      (e[k]),
            .valid_o    (v[k+1]),
            .psum_o     (ps[k+1]),
            .err_prod_o (ep[k+1]),
            .err_o      (e[k+1])
        );
    end
    assign out_valid  = v[GROUP_SIZE];
    assign psum_o     = ps[GROUP_SIZE];
    assign err_prod_o = ep[GROUP_SIZE];
    assign err_o      = e[GROUP_SIZE];
    always_comb begin
        pop = '0;
        for (int i = 0; i < GROUP_SIZE; i++) pop = pop + PCW'(err_flag_i[i]);
        cnt_sum = SW'(err_cnt_o) + SW'(pop);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            err_cnt_o <= '0;
        else if (clr_cnt)
            err_cnt_o <= '0;
        else if (in_valid && comp_en)
            err_cnt_o <= (cnt_sum > SW'({CNT_W{1'b1}})) ? '1 : cnt_sum[CNT_W-1:0];
endmodule

// File: tb/tb_grouped_ec_mac_array.sv
// tb_grouped_ec_mac_array: randomized and directed checks against a per-token arithmetic model
module tb_grouped_ec_mac_array;
    localparam int G = 4;
    localparam int D = 8;
    localparam int A = 24;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [G*D-1:0] weight_i = '0;
    logic [G*D-1:0] act_i = '0;
    logic [G-1:0]   err_flag_i = '0;
    logic [A-1:0]   psum_i = '0;
    logic [2*D-1:0] err_prod_i = '0;
    logic           err_i = 1'b0;
    logic           comp_en = 1'b0;
    logic           clr_cnt = 1'b0;
    logic [G*D-1:0] act_o, s_act;
    logic           out_valid, s_valid, err_o, s_err;
    logic [A-1:0]   psum_o, s_psum;
    logic [2*D-1:0] err_prod_o, s_ep;
    logic [15:0]    err_cnt_o;
    logic [1:0]     s_cnt;
    grouped_ec_mac_array dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .weight_i(weight_i), .act_i(act_i),
        .err_flag_i(err_flag_i), .psum_i(psum_i), .err_prod_i(err_prod_i), .err_i(err_i),
        .comp_en(comp_en), .clr_cnt(clr_cnt), .act_o(act_o), .out_valid(out_valid),
        .psum_o(psum_o), .err_prod_o(err_prod_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );
    grouped_ec_mac_array #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .weight_i(weight_i), .act_i(act_i),
        .err_flag_i(err_flag_i), .psum_i(psum_i), .err_prod_i(err_prod_i), .err_i(err_i),
        .comp_en(comp_en), .clr_cnt(clr_cnt), .act_o(s_act), .out_valid(s_valid),
        .psum_o(s_psum), .err_prod_o(s_ep), .err_o(s_err), .err_cnt_o(s_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        int             due;
        logic [A-1:0]   ps;
        logic [2*D-1:0] ep;
        logic           e;
    } exp_t;
    exp_t           pend[$];
    int             cycle = 0;
    int             n_chk = 0;
    int             n_pass = 0;
    int unsigned    cnt_m = 0;
    int unsigned    cnt_s_m = 0;
    logic [G*D-1:0] act_m = '0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask
    // walks the stage table with plain integers: each stage either adds or withholds its product
    function automatic exp_t model_tok();
        exp_t   t;
        longint s, p, pr;
        bit     e, f;
        s = longint'(psum_i);
        e = comp_en && err_i;
        p = e ? longint'($signed(err_prod_i)) : 0;
        for (int k = 0; k < G; k++) begin
            pr = longint'($signed(weight_i[k*D +: D])) * longint'($signed(act_i[k*D +: D]));
            f  = comp_en && err_flag_i[k];
            if (!f) s += pr;
            if (e) s += p;
            p = f ? pr : 0;
            e = f;
        end
        t.due = 0;
        t.ps  = s[A-1:0];
        t.ep  = p[2*D-1:0];
        t.e   = e;
        return t;
    endfunction
    task automatic cyc();
        exp_t        t;
        int unsigned pop;
        @(posedge clk);
        cycle++;
        if (!rst_n) begin
            pend.delete();
            cnt_m = 0;
            cnt_s_m = 0;
            act_m = '0;
        end else begin
            pop = $countones(err_flag_i);
            if (in_valid) begin
                t = model_tok();
                t.due = cycle + G;
                pend.push_back(t);
                act_m = act_i;
            end
            if (clr_cnt) begin
                cnt_m = 0;
                cnt_s_m = 0;
            end else if (in_valid && comp_en) begin
                cnt_m   = (cnt_m + pop > 65535) ? 65535 : cnt_m + pop;
                cnt_s_m = (cnt_s_m + pop > 3) ? 3 : cnt_s_m + pop;
            end
        end
        @(negedge clk);
        if (pend.size() > 0 && pend[0].due == cycle) begin
            t = pend.pop_front();
            check("out_valid", out_valid, 1);
            check("psum_o", psum_o, t.ps);
            check("err_o", err_o, t.e);
            check("err_prod_o", err_prod_o, t.ep);
            check("s_out", {s_valid, s_err, s_ep, s_psum}, {1'b1, t.e, t.ep, t.ps});
        end else begin
            check("out_valid_idle", {s_valid, out_valid}, 0);
        end
        check("err_cnt_o", err_cnt_o, cnt_m);
        check("sat_cnt", s_cnt, cnt_s_m);
        check("act_o", {s_act, act_o}, {act_m, act_m});
    endtask
    task automatic rand_in();
        weight_i   = $urandom;
        act_i      = $urandom;
        err_flag_i = 4'($urandom);
        psum_i     = 24'($urandom);
        err_prod_i = 16'($urandom);
        err_i      = 1'($urandom);
        comp_en    = 1'($urandom);
    endtask
    task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [3:0] f,
                        input logic [A-1:0] ps, input logic [15:0] ep, input logic e, input logic ce);
        weight_i = w; act_i = a; err_flag_i = f; psum_i = ps; err_prod_i = ep; err_i = e;
        comp_en = ce; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask
    task automatic send_rand();
        rand_in();
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask
    task automatic idle();
        in_valid = 1'b0;
        clr_cnt = 1'b0;
        cyc();
    endtask
    initial begin
        rand_in();
        in_valid = 1'b1;
        clr_cnt = 1'b1;
        repeat (3) cyc();
        check("rst_psum_o", psum_o, 0);
        check("rst_err_prod_o", err_prod_o, 0);
        check("rst_err_o", err_o, 0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        clr_cnt = 1'b0;
        repeat (3) idle();
        send(32'h03030303, 32'h03030303, 4'b0000, 24'd10, 16'd0, 1'b0, 1'b1);
        repeat (G) idle();
        check("t2_psum", psum_o, 46);
        check("t2_err", err_o, 0);
        check("t2_cnt", err_cnt_o, 0);
        send(32'h05040302, 32'h05040302, 4'b0010, 24'd0, 16'd0, 1'b0, 1'b1);
        repeat (G) idle();
        check("t3_psum", psum_o, 54);
        check("t3_err", err_o, 0);
        check("t3_cnt", err_cnt_o, 1);
        send(32'h05040302, 32'h05040302, 4'b1000, 24'd0, 16'd0, 1'b0, 1'b1);
        repeat (G) idle();
        check("t4_psum", psum_o, 29);
        check("t4_err", err_o, 1);
        check("t4_err_prod", err_prod_o, 25);
        send(32'h05040302, 32'h05040302, 4'b0000, 24'd100, 16'hFFF9, 1'b1, 1'b1);
        repeat (G) idle();
        check("t4_upstream_psum", psum_o, 147);
        check("t4_upstream_err", err_o, 0);
        send(32'h05040302, 32'h05040302, 4'b1111, 24'd100, 16'hFFF9, 1'b1, 1'b0);
        repeat (G) idle();
        check("t5_psum", psum_o, 154);
        check("t5_err", err_o, 0);
        check("t5_cnt", err_cnt_o, 2);
        send(32'h01010101, 32'h01010101, 4'b1111, 24'd0, 16'd0, 1'b0, 1'b1);
        check("sat_at_max", s_cnt, 3);
        check("cnt_after_sat", err_cnt_o, 6);
        repeat (G) idle();
        clr_cnt = 1'b1;
        send(32'h01010101, 32'h01010101, 4'b1111, 24'd0, 16'd0, 1'b0, 1'b1);
        clr_cnt = 1'b0;
        check("clr_wins", err_cnt_o, 0);
        check("clr_wins_sat", s_cnt, 0);
        repeat (G) idle();
        send_rand();
        send_rand();
        idle();
        send_rand();
        repeat (G + 1) idle();
        send_rand();
        send_rand();
        send_rand();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (G + 2) idle();
        for (int i = 0; i < 400; i++) begin
            rand_in();
            rst_n    = ($urandom_range(0, 149) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            clr_cnt  = ($urandom_range(0, 31) == 0);
            cyc();
        end
        rst_n = 1'b1;
        repeat (G + 2) idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
